// File: rtl/if_id_hazard.sv
// IF/ID pipeline register with load-use hazard detection, optional
// branch-shadow flush and a saturating stall-cycle counter.
module if_id_hazard #(
    parameter int DELAY_SLOT = 1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic [31:0]      pc,
    input  logic [31:0]      pc4,
    input  logic [31:0]      inst,
    input  logic [1:0]       pcsource,
    input  logic             ex_wreg,
    input  logic             ex_m2reg,
    input  logic [4:0]       ex_rn,
    output logic             stall,
    output logic             bubble,
    output logic [31:0]      d_pc,
    output logic [31:0]      d_pc4,
    output logic [31:0]      d_inst,
    output logic             d_valid,
    output logic [CNT_W-1:0] stall_cnt
);

    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rs;
    logic       uses_rt;
    logic       hz;

    assign op    = d_inst[31:26];
    assign funct = d_inst[5:0];
    assign rs    = d_inst[25:21];
    assign rt    = d_inst[20:16];

    // Which source fields of the decode-stage instruction are real register reads
    always_comb begin
        uses_rs = 1'b1;
        uses_rt = 1'b0;
        case (op)
            6'b000000: begin
                uses_rt = 1'b1;
                // sll/srl/sra take the shift amount from the instruction, not rs
                if (funct == 6'b000000 || funct == 6'b000010 || funct == 6'b000011)
                    uses_rs = 1'b0;
            end
            6'b000010, 6'b000011: uses_rs = 1'b0;
            6'b000100, 6'b000101, 6'b101011: uses_rt = 1'b1;
            default: ;
        endcase
    end

    // Load in EX whose destination feeds the instruction sitting in decode
    always_comb begin
        hz = d_valid & ex_wreg & ex_m2reg & (ex_rn != 5'd0) &
             ((uses_rs & (ex_rn == rs)) | (uses_rt & (ex_rn == rt)));
    end

    assign stall  = hz;
    assign bubble = hz;

    // Decode-stage register: reset, hold on hazard, flush redirect shadow, or load
    always_ff @(posedge clk) begin
        if (clrn) begin
            d_pc    <= '0;
            d_pc4   <= '0;
            d_inst  <= '0;
            d_valid <= 1'b0;
        end else if (hz) begin
            d_pc    <= d_pc;
            d_pc4   <= d_pc4;
            d_inst  <= d_inst;
            d_valid <= d_valid;
        end else if (DELAY_SLOT == 0 && pcsource != 2'b00) begin
            d_pc    <= pc;
            d_pc4   <= pc4;
            d_inst  <= '0;
            d_valid <= 1'b0;
        end else begin
            d_pc    <= pc;
            d_pc4   <= pc4;
            d_inst  <= inst;
            d_valid <= 1'b1;
        end
    end

    // Count stalled cycles, sticking at all-ones instead of wrapping
    always_ff @(posedge clk) begin
        if (clrn)
            stall_cnt <= '0;
        else if (hz && stall_cnt != '1)
            stall_cnt <= stall_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_if_id_hazard.sv
// Self-checking bench for if_id_hazard: three parameterisations share one
// stimulus stream (default, no delay slot, 4-bit counter).
module tb_if_id_hazard;

    logic        clk;
    logic        clrn;
    logic [31:0] pc, pc4, inst;
    logic [1:0]  pcsource;
    logic        ex_wreg, ex_m2reg;
    logic [4:0]  ex_rn;

    logic        s0_stall, s0_bubble, s0_valid;
    logic [31:0] s0_pc, s0_pc4, s0_inst;
    logic [15:0] s0_cnt;
    logic        s1_stall, s1_bubble, s1_valid;
    logic [31:0] s1_pc, s1_pc4, s1_inst;
    logic [15:0] s1_cnt;
    logic        s2_stall, s2_bubble, s2_valid;
    logic [31:0] s2_pc, s2_pc4, s2_inst;
    logic [3:0]  s2_cnt;

    int checks = 0;
    int errors = 0;

    if_id_hazard #(.DELAY_SLOT(1), .CNT_W(16)) dut (
        .clk(clk), .clrn(clrn), .pc(pc), .pc4(pc4), .inst(inst), .pcsource(pcsource),
        .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_rn(ex_rn),
        .stall(s0_stall), .bubble(s0_bubble), .d_pc(s0_pc), .d_pc4(s0_pc4),
        .d_inst(s0_inst), .d_valid(s0_valid), .stall_cnt(s0_cnt));

    if_id_hazard #(.DELAY_SLOT(0), .CNT_W(16)) dut_ns (
        .clk(clk), .clrn(clrn), .pc(pc), .pc4(pc4), .inst(inst), .pcsource(pcsource),
        .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_rn(ex_rn),
        .stall(s1_stall), .bubble(s1_bubble), .d_pc(s1_pc), .d_pc4(s1_pc4),
        .d_inst(s1_inst), .d_valid(s1_valid), .stall_cnt(s1_cnt));

    if_id_hazard #(.DELAY_SLOT(1), .CNT_W(4)) dut_c4 (
        .clk(clk), .clrn(clrn), .pc(pc), .pc4(pc4), .inst(inst), .pcsource(pcsource),
        .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_rn(ex_rn),
        .stall(s2_stall), .bubble(s2_bubble), .d_pc(s2_pc), .d_pc4(s2_pc4),
        .d_inst(s2_inst), .d_valid(s2_valid), .stall_cnt(s2_cnt));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] inst;
        bit          valid;
        int unsigned cnt;
    } mstate_t;

    mstate_t     m   [3];
    int          ds  [3] = '{1, 0, 1};
    int unsigned cap [3] = '{65535, 65535, 15};

    // Does instruction i read register r as a source operand?
    function automatic bit reads_reg(logic [31:0] i, logic [4:0] r);
        logic [5:0] op;
        logic [5:0] fn;
        bit rs_read, rt_read;
        op = i[31:26];
        fn = i[5:0];
        rs_read = !(op inside {6'd2, 6'd3}) && !(op == 6'd0 && (fn inside {6'd0, 6'd2, 6'd3}));
        rt_read = op inside {6'd0, 6'd4, 6'd5, 6'h2b};
        return (rs_read && i[25:21] == r) || (rt_read && i[20:16] == r);
    endfunction

    function automatic bit m_hz(mstate_t s);
        if (!s.valid || !ex_wreg || !ex_m2reg || ex_rn == 5'd0) return 1'b0;
        return reads_reg(s.inst, ex_rn);
    endfunction

    task automatic model_edge();
        for (int v = 0; v < 3; v++) begin
            bit h;
            h = m_hz(m[v]);
            if (clrn) begin
                m[v].pc = 0; m[v].pc4 = 0; m[v].inst = 0; m[v].valid = 0; m[v].cnt = 0;
            end else if (h) begin
                if (m[v].cnt < cap[v]) m[v].cnt = m[v].cnt + 1;
            end else if (ds[v] == 0 && pcsource != 2'b00) begin
                m[v].pc = pc; m[v].pc4 = pc4; m[v].inst = 0; m[v].valid = 0;
            end else begin
                m[v].pc = pc; m[v].pc4 = pc4; m[v].inst = inst; m[v].valid = 1;
            end
        end
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        for (int v = 0; v < 3; v++) begin
            logic [31:0] a_pc, a_pc4, a_inst, a_cnt;
            logic        a_stall, a_bubble, a_valid;
            logic        e_hz;
            case (v)
                0: begin a_pc = s0_pc; a_pc4 = s0_pc4; a_inst = s0_inst; a_valid = s0_valid;
                         a_stall = s0_stall; a_bubble = s0_bubble; a_cnt = 32'(s0_cnt); end
                1: begin a_pc = s1_pc; a_pc4 = s1_pc4; a_inst = s1_inst; a_valid = s1_valid;
                         a_stall = s1_stall; a_bubble = s1_bubble; a_cnt = 32'(s1_cnt); end
                default: begin a_pc = s2_pc; a_pc4 = s2_pc4; a_inst = s2_inst; a_valid = s2_valid;
                         a_stall = s2_stall; a_bubble = s2_bubble; a_cnt = 32'(s2_cnt); end
            endcase
            e_hz = m_hz(m[v]);
            chk($sformatf("v%0d_d_pc", v),     a_pc,           m[v].pc);
            chk($sformatf("v%0d_d_pc4", v),    a_pc4,          m[v].pc4);
            chk($sformatf("v%0d_d_inst", v),   a_inst,         m[v].inst);
            chk($sformatf("v%0d_d_valid", v),  32'(a_valid),   32'(m[v].valid));
            chk($sformatf("v%0d_stall", v),    32'(a_stall),   32'(e_hz));
            chk($sformatf("v%0d_bubble", v),   32'(a_bubble),  32'(e_hz));
            chk($sformatf("v%0d_stall_cnt", v), a_cnt,         m[v].cnt);
        end
    endtask

    // One clock: edge, settle, advance model, compare every instance
    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
        check_model();
    endtask

    task automatic drive(bit c, logic [31:0] p, logic [31:0] p4, logic [31:0] i,
                         logic [1:0] ps, bit w, bit ld, logic [4:0] rn);
        clrn = c; pc = p; pc4 = p4; inst = i; pcsource = ps;
        ex_wreg = w; ex_m2reg = ld; ex_rn = rn;
    endtask

    // ---------------- directed vector table (default instance) ----------------
    typedef struct {
        bit          clrn;
        logic [31:0] pc, pc4, inst;
        logic [1:0]  pcsource;
        bit          wreg, m2reg;
        logic [4:0]  rn;
        bit          e_stall;
        logic [31:0] e_pc, e_pc4, e_inst;
        bit          e_valid;
        int unsigned e_cnt;
    } vec_t;

    localparam int NV = 16;
    vec_t tbl [NV];

    logic [5:0] ops [10];
    logic [5:0] fns [6];

    initial begin
        // clrn pc pc4 inst pcs w m rn | stall d_pc d_pc4 d_inst valid cnt
        tbl[0]  = '{1, 32'h123, 32'h127, 32'hFFFFFFFF, 2'd3, 1, 1, 5'd31, 0, 0, 0, 32'h0, 0, 0};
        tbl[1]  = '{1, 32'h123, 32'h127, 32'hFFFFFFFF, 2'd3, 1, 1, 5'd31, 0, 0, 0, 32'h0, 0, 0};
        tbl[2]  = '{0, 0,  4,  32'h8C010000, 2'd0, 0, 0, 5'd0, 0, 0,  4,  32'h8C010000, 1, 0};
        tbl[3]  = '{0, 4,  8,  32'h00221820, 2'd0, 0, 0, 5'd0, 0, 4,  8,  32'h00221820, 1, 0};
        tbl[4]  = '{0, 8,  12, 32'h00000000, 2'd0, 1, 1, 5'd1, 1, 4,  8,  32'h00221820, 1, 1};
        tbl[5]  = '{0, 8,  12, 32'h00000000, 2'd0, 1, 0, 5'd1, 0, 8,  12, 32'h00000000, 1, 1};
        tbl[6]  = '{0, 12, 16, 32'h00221820, 2'd0, 0, 0, 5'd0, 0, 12, 16, 32'h00221820, 1, 1};
        tbl[7]  = '{0, 16, 20, 32'h20420001, 2'd0, 1, 1, 5'd2, 1, 12, 16, 32'h00221820, 1, 2};
        tbl[8]  = '{0, 16, 20, 32'h20420001, 2'd0, 1, 1, 5'd0, 0, 16, 20, 32'h20420001, 1, 2};
        tbl[9]  = '{0, 20, 24, 32'h08A00010, 2'd0, 1, 1, 5'd0, 0, 20, 24, 32'h08A00010, 1, 2};
        tbl[10] = '{0, 24, 28, 32'h20420001, 2'd1, 1, 1, 5'd5, 0, 24, 28, 32'h20420001, 1, 2};
        tbl[11] = '{0, 28, 32, 32'h00000000, 2'd0, 1, 0, 5'd2, 0, 28, 32, 32'h00000000, 1, 2};
        tbl[12] = '{0, 32, 36, 32'h00221820, 2'd0, 0, 0, 5'd0, 0, 32, 36, 32'h00221820, 1, 2};
        tbl[13] = '{0, 36, 40, 32'h11111111, 2'd2, 1, 1, 5'd1, 1, 32, 36, 32'h00221820, 1, 3};
        tbl[14] = '{1, 36, 40, 32'h11111111, 2'd2, 1, 1, 5'd1, 0, 0,  0,  32'h00000000, 0, 0};
        tbl[15] = '{0, 40, 44, 32'h08000010, 2'd0, 0, 0, 5'd0, 0, 40, 44, 32'h08000010, 1, 0};

        drive(1, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].clrn, tbl[i].pc, tbl[i].pc4, tbl[i].inst, tbl[i].pcsource,
                  tbl[i].wreg, tbl[i].m2reg, tbl[i].rn);
            step();
            chk($sformatf("tbl%0d_stall", i),   32'(s0_stall),  32'(tbl[i].e_stall));
            chk($sformatf("tbl%0d_bubble", i),  32'(s0_bubble), 32'(tbl[i].e_stall));
            chk($sformatf("tbl%0d_d_pc", i),    s0_pc,          tbl[i].e_pc);
            chk($sformatf("tbl%0d_d_pc4", i),   s0_pc4,         tbl[i].e_pc4);
            chk($sformatf("tbl%0d_d_inst", i),  s0_inst,        tbl[i].e_inst);
            chk($sformatf("tbl%0d_d_valid", i), 32'(s0_valid),  32'(tbl[i].e_valid));
            chk($sformatf("tbl%0d_cnt", i),     32'(s0_cnt),    tbl[i].e_cnt);
        end

        // Redirect shadow: kept with a delay slot, flushed without one
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        step();
        drive(0, 32'h40, 32'h44, 32'h20420001, 2'd1, 0, 0, 0);
        step();
        chk("ds1_inst",   s0_inst,        32'h20420001);
        chk("ds1_valid",  32'(s0_valid),  32'd1);
        chk("ds0_inst",   s1_inst,        32'h0);
        chk("ds0_valid",  32'(s1_valid),  32'd0);
        chk("ds0_pc4",    s1_pc4,         32'h44);
        chk("ds0_pc",     s1_pc,          32'h40);

        // Counter saturation: one long-lived load hazard on ADD $3,$1,$2
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        step();
        drive(0, 32'h100, 32'h104, 32'h00221820, 2'd0, 0, 0, 0);
        step();
        drive(0, 32'h104, 32'h108, 32'h00000000, 2'd0, 1, 1, 5'd1);
        for (int i = 0; i < 20; i++) step();
        chk("sat_c4_cnt",   32'(s2_cnt),   32'd15);
        chk("sat_c4_stall", 32'(s2_stall), 32'd1);
        chk("sat_c16_cnt",  32'(s0_cnt),   32'd20);
        chk("sat_c4_inst",  s2_inst,       32'h00221820);
        drive(1, 32'h104, 32'h108, 32'h00000000, 2'd0, 1, 1, 5'd1);
        step();
        chk("sat_rst_cnt",   32'(s2_cnt),   32'd0);
        chk("sat_rst_stall", 32'(s2_stall), 32'd0);

        // Randomised traffic against the model
        ops = '{6'd0, 6'd0, 6'd2, 6'd3, 6'd4, 6'd5, 6'd8, 6'h23, 6'h2b, 6'h0f};
        fns = '{6'd0, 6'd2, 6'd3, 6'h20, 6'h21, 6'h2a};
        for (int n = 0; n < 1500; n++) begin
            logic [31:0] r;
            r = $urandom;
            r[31:26] = ($urandom_range(0, 9) == 9) ? 6'($urandom) : ops[$urandom_range(0, 9)];
            r[25:21] = 5'($urandom_range(0, 3));
            r[20:16] = 5'($urandom_range(0, 3));
            r[5:0]   = fns[$urandom_range(0, 5)];
            drive(($urandom_range(0, 39) == 0), $urandom, $urandom, r,
                  ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'd0,
                  ($urandom_range(0, 3) != 0), 1'($urandom), 5'($urandom_range(0, 3)));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
